// File: rtl/ac97_dma_arbiter.sv
// ----------------------------------------------------------------------------
// ac97_dma_arbiter
//
// Shares the single AC'97 Wishbone master port between the playback DMA
// engine (dmar, memory reads) and the record DMA engine (dmaw, memory writes).
// Each engine asks for one 32-bit single-beat transfer at a time. The arbiter
// grants round-robin, runs one Wishbone classic cycle, and returns ack/data
// to the owner. A per-cycle watchdog aborts a cycle the slave never acks.
//
// Parameters
//   TIMEOUT    max cycles a bus cycle may wait for wbm_ack_i (>= 2)
//
// Ports
//   sys_clk, sys_rst_n     clock (rising edge), synchronous active-low reset
//   dmar_req/adr           playback read request and word address
//   dmar_ack/err/dat       read done (data valid) / read aborted / read data
//   dmaw_req/adr/dat       record write request, word address, write data
//   dmaw_ack/err           write done / write aborted
//   wbm_*                  Wishbone classic master port (registered outputs)
//   busy                   a bus cycle is in progress
// ----------------------------------------------------------------------------
module ac97_dma_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,

  input  logic        dmar_req,
  input  logic [29:0] dmar_adr,
  output logic        dmar_ack,
  output logic        dmar_err,
  output logic [31:0] dmar_dat,

  input  logic        dmaw_req,
  input  logic [29:0] dmaw_adr,
  input  logic [31:0] dmaw_dat,
  output logic        dmaw_ack,
  output logic        dmaw_err,

  output logic [31:0] wbm_adr_o,
  output logic [2:0]  wbm_cti_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [31:0] wbm_dat_o,

  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]       r_state;
  logic             r_last_wr;   // 1: previous completed transfer was a write
  logic [CNT_W-1:0] r_cnt;
  logic             r_cyc;
  logic             r_we;
  logic [31:0]      r_adr;
  logic [31:0]      r_wdat;

  logic w_in_read;
  logic w_in_write;
  logic w_active;
  logic w_cnt_last;
  logic w_timeout;
  logic w_end;
  logic w_pick_wr;
  logic w_any_req;

  assign w_in_read  = (r_state == ST_READ);
  assign w_in_write = (r_state == ST_WRITE);
  assign w_active   = w_in_read | w_in_write;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // An ack on the final allowed cycle still counts as success.
  assign w_timeout  = w_cnt_last & ~wbm_ack_i;
  assign w_end      = w_active & (wbm_ack_i | w_cnt_last);

  // Write wins only if it is alone, or on a tie when the last transfer was a
  // read. Reset marks the last transfer as a write, so reads win the first tie.
  assign w_any_req  = dmar_req | dmaw_req;
  assign w_pick_wr  = dmaw_req & (~dmar_req | ~r_last_wr);

  // Completion strobes are combinational so the requester sees them in the
  // same cycle as the slave ack. A cycle being killed by reset reports nothing.
  assign dmar_ack   = sys_rst_n & w_in_read  & wbm_ack_i;
  assign dmar_err   = sys_rst_n & w_in_read  & w_timeout;
  assign dmaw_ack   = sys_rst_n & w_in_write & wbm_ack_i;
  assign dmaw_err   = sys_rst_n & w_in_write & w_timeout;
  assign dmar_dat   = wbm_dat_i;

  assign wbm_adr_o  = r_adr;
  assign wbm_cti_o  = 3'b000;
  assign wbm_sel_o  = 4'hf;
  assign wbm_we_o   = r_we;
  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_cyc;
  assign wbm_dat_o  = r_wdat;
  assign busy       = w_active;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_last_wr <= 1'b1;
      r_cnt     <= '0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Requests are only looked at here; the loser simply keeps its
          // request held and is served after the current transfer.
          if (w_any_req) begin
            r_state <= w_pick_wr ? ST_WRITE : ST_READ;
            r_cyc   <= 1'b1;
            r_we    <= w_pick_wr;
            r_adr   <= {(w_pick_wr ? dmaw_adr : dmar_adr), 2'b00};
            r_wdat  <= dmaw_dat;
            r_cnt   <= '0;
          end
        end
        ST_READ, ST_WRITE: begin
          // Dropping the request mid-cycle does not abort; only ack or the
          // watchdog ends the cycle, always through one IDLE cycle.
          if (w_end) begin
            r_state   <= ST_IDLE;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_last_wr <= w_in_write;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule
